// File: rtl/detector_golpes.sv
// detector_golpes: per-pad drum hit detector.
// Each channel compares its sample stream against a calibrated baseline plus threshold, fires a
// single registered golpe pulse per strike, then holds off for HOLDOFF cycles and waits for the
// signal to fall below the hysteresis level before re-arming. The peak of each strike is kept.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high; clears all state
//   muestra   packed samples, channel i at [i*ANCHO +: ANCHO]
//   valido    per-channel sample strobe
//   calibrar  per-channel calibration level; captures the baseline and forces idle
//   golpe     one-cycle hit pulse per channel
//   activo    high while the channel is in hold-off or waiting to re-arm
//   pico      peak sample of the most recent strike, per channel
module detector_golpes #(
  parameter int unsigned CANALES    = 5,
  parameter int unsigned ANCHO      = 12,
  parameter int unsigned UMBRAL     = 800,
  parameter int unsigned HISTERESIS = 400,
  parameter int unsigned HOLDOFF    = 2_500_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CANALES*ANCHO-1:0]   muestra,
  input  logic [CANALES-1:0]         valido,
  input  logic [CANALES-1:0]         calibrar,
  output logic [CANALES-1:0]         golpe,
  output logic [CANALES-1:0]         activo,
  output logic [CANALES*ANCHO-1:0]   pico
);

  typedef enum logic [1:0] {
    StReposo  = 2'd0,
    StBloqueo = 2'd1,
    StRearme  = 2'd2
  } estado_e;

  localparam logic [ANCHO:0] UmbralW     = (ANCHO+1)'(UMBRAL);
  localparam logic [ANCHO:0] HisteresisW = (ANCHO+1)'(HISTERESIS);
  localparam logic [21:0]    HoldoffUlt  = 22'(HOLDOFF - 1);

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    logic [ANCHO-1:0] s;
    logic [ANCHO:0]   suma_disparo, suma_rearme;
    logic [ANCHO-1:0] disparo, rearme;

    estado_e          state_q, state_d;
    logic [ANCHO-1:0] base_q, base_d;
    logic [ANCHO-1:0] pico_q, pico_d;
    logic [21:0]      cnt_q, cnt_d;
    logic             golpe_q, golpe_d;
    logic             cal_q;

    assign s = muestra[i*ANCHO +: ANCHO];

    // Levels saturate at full scale so a high baseline can never wrap to a low trigger level.
    always_comb begin
      suma_disparo = {1'b0, base_q} + UmbralW;
      suma_rearme  = {1'b0, base_q} + HisteresisW;
      disparo      = suma_disparo[ANCHO] ? {ANCHO{1'b1}} : suma_disparo[ANCHO-1:0];
      rearme       = suma_rearme[ANCHO]  ? {ANCHO{1'b1}} : suma_rearme[ANCHO-1:0];
    end

    always_comb begin
      state_d = state_q;
      base_d  = base_q;
      pico_d  = pico_q;
      cnt_d   = cnt_q;
      golpe_d = 1'b0;
      if (calibrar[i]) begin
        // Calibration aborts any strike in progress; pico is left untouched.
        state_d = StReposo;
        cnt_d   = '0;
        if (valido[i]) begin
          base_d = s;
        end
      end else begin
        unique case (state_q)
          StReposo: begin
            // cal_q blocks a hit in the first cycle after calibration is released.
            if (valido[i] && (s > disparo) && !cal_q) begin
              golpe_d = 1'b1;
              pico_d  = s;
              cnt_d   = '0;
              state_d = StBloqueo;
            end
          end
          StBloqueo: begin
            if (valido[i] && (s > pico_q)) begin
              pico_d = s;
            end
            if (cnt_q == HoldoffUlt) begin
              state_d = StRearme;
            end else begin
              cnt_d = cnt_q + 22'd1;
            end
          end
          StRearme: begin
            if (valido[i] && (s < rearme)) begin
              state_d = StReposo;
            end
          end
          default: state_d = StReposo;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StReposo;
        base_q  <= '0;
        pico_q  <= '0;
        cnt_q   <= '0;
        golpe_q <= 1'b0;
        cal_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        base_q  <= base_d;
        pico_q  <= pico_d;
        cnt_q   <= cnt_d;
        golpe_q <= golpe_d;
        cal_q   <= calibrar[i];
      end
    end

    assign golpe[i]                 = golpe_q;
    assign activo[i]                = (state_q != StReposo);
    assign pico[i*ANCHO +: ANCHO]   = pico_q;
  end

endmodule

// File: tb/tb_detector_golpes.sv
// Self-checking bench for detector_golpes with a shortened hold-off window.
// Expected golpe pulses go into a queue when the stimulus is driven; a negedge monitor pops and
// compares every pulse the DUT produces, so missing, late, wide or spurious pulses are caught.
module tb_detector_golpes;

  localparam int CANALES = 5;
  localparam int ANCHO   = 12;
  localparam int HOLDOFF = 100;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [CANALES*ANCHO-1:0] muestra = '0;
  logic [CANALES-1:0]       valido = '0;
  logic [CANALES-1:0]       calibrar = '0;
  logic [CANALES-1:0]       golpe;
  logic [CANALES-1:0]       activo;
  logic [CANALES*ANCHO-1:0] pico;

  typedef struct {
    int                 cyc;
    logic [CANALES-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   last_hit = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  detector_golpes #(
    .CANALES   (CANALES),
    .ANCHO     (ANCHO),
    .UMBRAL    (800),
    .HISTERESIS(400),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .muestra (muestra),
    .valido  (valido),
    .calibrar(calibrar),
    .golpe   (golpe),
    .activo  (activo),
    .pico    (pico)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && !reset && (golpe !== '0)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL golpe_unexpected: got %b at cycle %0d, required none", golpe, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((golpe !== e.mask) || (cyc !== e.cyc)) begin
          n_err++;
          $display("FAIL golpe_match: got %b at cycle %0d, required %b at cycle %0d",
                   golpe, cyc, e.mask, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // One sample on one channel, then one idle cycle; returns just after the result is visible.
  task automatic put(input int ch, input int val, input bit hit);
    logic [CANALES-1:0] m;
    @(negedge clk);
    muestra[ch*ANCHO +: ANCHO] = val[ANCHO-1:0];
    valido = '0;
    valido[ch] = 1'b1;
    if (hit) begin
      m = '0;
      m[ch] = 1'b1;
      exp_q.push_back('{cyc: cyc + 1, mask: m});
      last_hit = cyc + 1;
    end
    @(negedge clk);
    valido = '0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (golpe !== '0) begin
      n_err++; $display("FAIL reset_golpe: got %b, required 0", golpe);
    end
    n_cmp++;
    if (activo !== '0) begin
      n_err++; $display("FAIL reset_activo: got %b, required 0", activo);
    end
    n_cmp++;
    if (pico !== '0) begin
      n_err++; $display("FAIL reset_pico: got %h, required 0", pico);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    #1;
  endtask

  task automatic test_hit_basico();
    put(0, 0, 0);
    put(0, 500, 0);
    put(0, 800, 0);  // equal to disparo: no hit
    n_cmp++;
    if (activo !== 5'b00000) begin
      n_err++; $display("FAIL equal_disparo_activo: got %b, required 00000", activo);
    end
    put(0, 900, 1);
    n_cmp++;
    if (activo !== 5'b00001) begin
      n_err++; $display("FAIL hit_activo: got %b, required 00001", activo);
    end
    n_cmp++;
    if (pico[0 +: ANCHO] !== 12'd900) begin
      n_err++; $display("FAIL hit_pico: got %0d, required 900", pico[0 +: ANCHO]);
    end
  endtask

  task automatic test_holdoff();
    put(0, 1500, 0);
    put(0, 1200, 0);
    n_cmp++;
    if (pico[0 +: ANCHO] !== 12'd1500) begin
      n_err++; $display("FAIL holdoff_pico_max: got %0d, required 1500", pico[0 +: ANCHO]);
    end
    // Sample captured on the last hold-off edge still updates the peak.
    while (cyc < last_hit + HOLDOFF - 2) @(negedge clk);
    put(0, 2000, 0);
    n_cmp++;
    if (pico[0 +: ANCHO] !== 12'd2000) begin
      n_err++; $display("FAIL holdoff_last_cycle_pico: got %0d, required 2000", pico[0 +: ANCHO]);
    end
    n_cmp++;
    if (activo[0] !== 1'b1) begin
      n_err++; $display("FAIL rearme_activo: got %b, required 1", activo[0]);
    end
    put(0, 3000, 0);  // in REARME: peak frozen
    n_cmp++;
    if (pico[0 +: ANCHO] !== 12'd2000) begin
      n_err++; $display("FAIL rearme_pico_frozen: got %0d, required 2000", pico[0 +: ANCHO]);
    end
    put(0, 600, 0);
    put(0, 900, 0);   // not re-armed yet: no hit
    put(0, 400, 0);   // equal to rearme: stays
    n_cmp++;
    if (activo[0] !== 1'b1) begin
      n_err++; $display("FAIL equal_rearme_activo: got %b, required 1", activo[0]);
    end
    put(0, 300, 0);
    n_cmp++;
    if (activo[0] !== 1'b0) begin
      n_err++; $display("FAIL rearmed_activo: got %b, required 0", activo[0]);
    end
    put(0, 900, 1);
    n_cmp++;
    if (pico[0 +: ANCHO] !== 12'd900) begin
      n_err++; $display("FAIL second_hit_pico: got %0d, required 900", pico[0 +: ANCHO]);
    end
  endtask

  task automatic test_simultaneo();
    @(negedge clk);
    for (int c = 0; c < CANALES; c++) muestra[c*ANCHO +: ANCHO] = 12'd1000;
    valido = '1;
    exp_q.push_back('{cyc: cyc + 1, mask: 5'b11111});
    @(negedge clk);
    valido = '0;
    #1;
    n_cmp++;
    if (activo !== 5'b11111) begin
      n_err++; $display("FAIL simul_activo: got %b, required 11111", activo);
    end
    n_cmp++;
    if (pico !== {5{12'd1000}}) begin
      n_err++; $display("FAIL simul_pico: got %h, required %h", pico, {5{12'd1000}});
    end
  endtask

  task automatic test_calib_bloqueo();
    @(negedge clk);
    calibrar[1] = 1'b1;
    muestra[1*ANCHO +: ANCHO] = 12'd0;
    valido[1] = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (activo !== 5'b11101) begin
      n_err++; $display("FAIL calib_abort_activo: got %b, required 11101", activo);
    end
    // Baseline is 0 and channel idle, but calibrar still high: 4000 must not hit.
    muestra[1*ANCHO +: ANCHO] = 12'd4000;
    @(negedge clk);
    calibrar[1] = 1'b0;
    valido = '0;
    #1;
    n_cmp++;
    if (pico[1*ANCHO +: ANCHO] !== 12'd1000) begin
      n_err++; $display("FAIL calib_pico_kept: got %0d, required 1000", pico[1*ANCHO +: ANCHO]);
    end
  endtask

  task automatic test_calib_saturacion();
    @(negedge clk);
    calibrar[2] = 1'b1;
    muestra[2*ANCHO +: ANCHO] = 12'd3500;
    valido[2] = 1'b1;
    @(negedge clk);
    calibrar[2] = 1'b0;
    valido = '0;
    put(2, 4095, 0);
    put(2, 4094, 0);
    n_cmp++;
    if (activo[2] !== 1'b0) begin
      n_err++; $display("FAIL sat_activo: got %b, required 0", activo[2]);
    end
    // Hit suppressed in the cycle calibrar falls, even with a qualifying sample.
    @(negedge clk);
    calibrar[3] = 1'b1;
    muestra[3*ANCHO +: ANCHO] = 12'd0;
    valido[3] = 1'b1;
    @(negedge clk);
    calibrar[3] = 1'b0;
    muestra[3*ANCHO +: ANCHO] = 12'd1000;
    @(negedge clk);
    valido = '0;
    #1;
    n_cmp++;
    if (activo[3] !== 1'b0) begin
      n_err++; $display("FAIL calib_fall_activo: got %b, required 0", activo[3]);
    end
    put(3, 1000, 1);
    n_cmp++;
    if (activo[3] !== 1'b1) begin
      n_err++; $display("FAIL post_calib_activo: got %b, required 1", activo[3]);
    end
  endtask

  task automatic test_reset_async();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({golpe, activo, pico} !== '0) begin
      n_err++; $display("FAIL async_reset: got g=%b a=%b p=%h, required all 0", golpe, activo, pico);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    put(0, 801, 1);
    n_cmp++;
    if (pico[0 +: ANCHO] !== 12'd801) begin
      n_err++; $display("FAIL post_reset_pico: got %0d, required 801", pico[0 +: ANCHO]);
    end
    put(1, 900, 1);  // baseline of channel 1 was cleared by reset
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    valido = '0;
    valido[4] = 1'b1;
    muestra[4*ANCHO +: ANCHO] = 12'd100;
    @(negedge clk);
    muestra[4*ANCHO +: ANCHO] = 12'd900;
    exp_q.push_back('{cyc: cyc + 1, mask: 5'b10000});
    @(negedge clk);
    muestra[4*ANCHO +: ANCHO] = 12'd1300;
    @(negedge clk);
    muestra[4*ANCHO +: ANCHO] = 12'd1100;
    @(negedge clk);
    valido = '0;
    #1;
    n_cmp++;
    if (pico[4*ANCHO +: ANCHO] !== 12'd1300) begin
      n_err++; $display("FAIL b2b_pico: got %0d, required 1300", pico[4*ANCHO +: ANCHO]);
    end
  endtask

  initial begin
    test_reset();
    test_hit_basico();
    test_holdoff();
    do_reset();
    test_simultaneo();
    test_calib_bloqueo();
    test_calib_saturacion();
    test_reset_async();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL missing_golpe: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
